// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: parametrised configuration-register bank slave.
//
// Transfer handshake: a transfer is accepted on a rising edge where
// sel=1, ready=1 and rst=0. At that edge wr/addr/wdata/wstrb are captured.
// The slave then holds ready low for WAIT_STATES cycles (BUSY). After that it
// enters RESP for one cycle with done=1, ready=1 and err valid. A new transfer
// may be accepted during that RESP cycle (back-to-back). The write and the
// rdata/err update take effect on the edge that enters RESP.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   sel    - transfer request
//   wr     - 1=write, 0=read
//   addr   - word address
//   wdata  - write data
//   wstrb  - byte write enables
//   rdata  - read data, updated only by read completions
//   ready  - slave can accept a transfer this cycle
//   done   - one-cycle completion pulse
//   err    - error response, qualified by done
module reg_bank_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
    parameter logic [DEPTH-1:0] RO_MASK = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sel,
    input  logic                      wr,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      ready,
    output logic                      done,
    output logic                      err
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    generate
        if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH) || (DATA_WIDTH % 8) != 0 ||
            WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_params
            $error("reg_bank_ctrl: illegal parameter combination");
        end
    endgenerate

    logic [1:0]              state;
    logic [3:0]              cnt;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];

    logic                    h_wr;
    logic [ADDR_WIDTH-1:0]   h_addr;
    logic [DATA_WIDTH-1:0]   h_wdata;
    logic [NB-1:0]           h_wstrb;

    logic                    accept;
    logic                    commit;
    logic                    c_wr;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_wdata;
    logic [NB-1:0]           c_wstrb;
    logic [IW-1:0]           idx;
    logic                    in_range;
    logic                    wr_ok;
    logic [DATA_WIDTH-1:0]   cur;
    logic [DATA_WIDTH-1:0]   merged;

    assign ready  = (state != BUSY);
    assign done   = (state == RESP);
    assign err    = err_q && (state == RESP);
    assign accept = sel && ready && !rst;

    // With no wait states the transfer commits on its own acceptance edge,
    // before the holding registers are loaded, so the live inputs are used.
    assign commit  = (state == BUSY && cnt == 4'd0) || (accept && WAIT_STATES == 0);
    assign c_wr    = (WAIT_STATES == 0) ? wr    : h_wr;
    assign c_addr  = (WAIT_STATES == 0) ? addr  : h_addr;
    assign c_wdata = (WAIT_STATES == 0) ? wdata : h_wdata;
    assign c_wstrb = (WAIT_STATES == 0) ? wstrb : h_wstrb;

    assign idx      = c_addr[IW-1:0];
    assign in_range = ({1'b0, c_addr} < DEPTH_W);
    assign wr_ok    = in_range && !RO_MASK[idx];
    assign cur      = regs[idx];

    always_comb begin
        merged = cur;
        for (int k = 0; k < NB; k++) begin
            if (c_wstrb[k]) merged[8*k +: 8] = c_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            err_q   <= 1'b0;
            rdata   <= '0;
            h_wr    <= 1'b0;
            h_addr  <= '0;
            h_wdata <= '0;
            h_wstrb <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        if (WAIT_STATES > 0) begin
                            state <= BUSY;
                            cnt   <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= RESP;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                h_wr    <= wr;
                h_addr  <= addr;
                h_wdata <= wdata;
                h_wstrb <= wstrb;
            end

            if (commit) begin
                if (c_wr) begin
                    err_q <= !wr_ok;
                    if (wr_ok) regs[idx] <= merged;
                end else begin
                    err_q <= !in_range;
                    rdata <= in_range ? cur : '0;
                end
            end
        end
    end

endmodule
